spike_axi_master: RTL and testbench

- Synthesizable successor to the DPI-driven spike agent.
- Takes single memory requests on a valid/ready command port (Spike-side shim or RTL core) and issues one AXI transaction per request on the CPUNC master bus.
- Generalised in four ways:
  - AXI data width: 32 or 64.
  - Byte-lane steering and strobes for 1/2/4/8-byte accesses.
  - AW and W issued concurrently.
  - Response and timeout errors are reported to the requester; it does not hang.

---
 rtl/spike_axi_pkg.sv | 36 +++
 rtl/spike_axi_lane_steer.sv | 51 +++++
 rtl/spike_axi_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_spike_axi_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_axi_pkg.sv
// Shared types, AXI constants and request legality check for the spike AXI master.
package spike_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_D    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    RSP     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BUS     = 2'b01,
    ERR_ALIGN   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // An access is legal when it fits the bus and is naturally aligned.
  function automatic logic size_legal(input logic [2:0] addr_lo, input logic [1:0] size,
                                      input int unsigned dw);
    logic [2:0] mask;
    case (size)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return !((size == 2'd3) && (dw == 32)) && ((addr_lo & mask) == 3'b000);
  endfunction

endpackage

// File: rtl/spike_axi_lane_steer.sv
// Combinational byte-lane steering: write data/strobe placement and read-data extraction.
module spike_axi_lane_steer
  import spike_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  localparam int unsigned LANE_W = $clog2(AXI_DATA_WIDTH / 8),
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8
) (
  input  logic [LANE_W-1:0]         i_lane,
  input  logic [1:0]                i_size,
  input  logic [63:0]               i_wdata,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata_c,
  output logic [STRB_W-1:0]         o_wstrb_c,
  output logic [63:0]               o_rdata_c
);

  logic [7:0]                w_bytes;
  logic [63:0]               w_rmask;
  logic [AXI_DATA_WIDTH-1:0] w_rshift;
  logic                      w_unused_wdata;

  always_comb begin
    w_bytes = 8'h01;
    w_rmask = 64'h0000_0000_0000_00FF;
    case (i_size)
      2'd1: begin
        w_bytes = 8'h03;
        w_rmask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        w_bytes = 8'h0F;
        w_rmask = 64'h0000_0000_FFFF_FFFF;
      end
      2'd3: begin
        w_bytes = 8'hFF;
        w_rmask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: ;
    endcase
  end

  assign o_wdata_c = AXI_DATA_WIDTH'(i_wdata) << {i_lane, 3'b000};
  assign o_wstrb_c = STRB_W'(w_bytes) << i_lane;
  assign w_rshift  = i_rdata >> {i_lane, 3'b000};
  assign o_rdata_c = 64'(w_rshift) & w_rmask;

  // Upper write-data bits cannot reach a 32-bit bus; legal requests never need them.
  assign w_unused_wdata = ^i_wdata;

endmodule

// File: rtl/spike_axi_master.sv
// Single-outstanding AXI master: one valid/ready memory request becomes one AXI transaction,
// with lane steering, concurrent AW/W, error reporting and a wait-state timeout.
module spike_axi_master
  import spike_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter logic [7:0]  AXI_ID         = 8'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8
) (
  input  logic                      CPUNC_ACLK,
  input  logic                      CPUNC_ARESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]                req_size,
  input  logic [63:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [63:0]               rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [7:0]                CPUNC_AWID,
  output logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
  output logic [7:0]                CPUNC_AWLEN,
  output logic [2:0]                CPUNC_AWSIZE,
  output logic [1:0]                CPUNC_AWBURST,
  output logic                      CPUNC_AWVALID,
  input  logic                      CPUNC_AWREADY,
  output logic [7:0]                CPUNC_WID,
  output logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
  output logic [STRB_W-1:0]         CPUNC_WSTRB,
  output logic                      CPUNC_WLAST,
  output logic                      CPUNC_WVALID,
  input  logic                      CPUNC_WREADY,
  input  logic [7:0]                CPUNC_BID,
  input  logic [1:0]                CPUNC_BRESP,
  input  logic                      CPUNC_BVALID,
  output logic                      CPUNC_BREADY,
  output logic [7:0]                CPUNC_ARID,
  output logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
  output logic [7:0]                CPUNC_ARLEN,
  output logic [2:0]                CPUNC_ARSIZE,
  output logic [1:0]                CPUNC_ARBURST,
  output logic                      CPUNC_ARVALID,
  input  logic                      CPUNC_ARREADY,
  input  logic [7:0]                CPUNC_RID,
  input  logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
  input  logic [1:0]                CPUNC_RRESP,
  input  logic                      CPUNC_RLAST,
  input  logic                      CPUNC_RVALID,
  output logic                      CPUNC_RREADY
);

  localparam int unsigned LANE_W = $clog2(AXI_DATA_WIDTH / 8);

  state_t                    r_state, w_state_nxt;
  rsp_err_t                  w_rsp_err;
  logic                      w_req_hs, w_legal, w_acc_rd, w_acc_wr;
  logic                      w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_b_hs;
  logic                      w_tmo_hit, w_abort, w_drain_nxt;
  logic                      r_drain, r_aw_done, r_w_done;
  logic [31:0]               r_tmo;
  logic [LANE_W-1:0]         r_lane, w_lane;
  logic [1:0]                r_size, w_size;
  logic [AXI_DATA_WIDTH-1:0] w_wdata_c;
  logic [STRB_W-1:0]         w_wstrb_c;
  logic [63:0]               w_rdata_c;
  logic                      w_unused_ids;

  assign CPUNC_AWID    = AXI_ID;
  assign CPUNC_WID     = AXI_ID;
  assign CPUNC_ARID    = AXI_ID;
  assign CPUNC_AWLEN   = 8'd0;
  assign CPUNC_ARLEN   = 8'd0;
  assign CPUNC_AWBURST = BURST_INCR;
  assign CPUNC_ARBURST = BURST_INCR;
  assign w_unused_ids  = ^{CPUNC_BID, CPUNC_RID, CPUNC_RLAST};

  assign w_legal   = size_legal(req_addr[2:0], req_size, AXI_DATA_WIDTH);
  assign w_req_hs  = req_valid && req_ready;
  assign w_acc_rd  = w_req_hs && w_legal && !req_write;
  assign w_acc_wr  = w_req_hs && w_legal && req_write;
  assign w_aw_hs   = CPUNC_AWVALID && CPUNC_AWREADY;
  assign w_w_hs    = CPUNC_WVALID && CPUNC_WREADY;
  assign w_ar_hs   = CPUNC_ARVALID && CPUNC_ARREADY;
  assign w_r_hs    = CPUNC_RVALID && CPUNC_RREADY;
  assign w_b_hs    = CPUNC_BVALID && CPUNC_BREADY;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && ((r_tmo + 32'd1) >= 32'(TIMEOUT_CYCLES));

  // Lanes come from the live request while accepting, from the captured request afterwards.
  assign w_lane = (r_state == IDLE) ? req_addr[LANE_W-1:0] : r_lane;
  assign w_size = (r_state == IDLE) ? req_size : r_size;

  spike_axi_lane_steer #(.AXI_DATA_WIDTH(AXI_DATA_WIDTH)) u_steer (
    .i_lane    (w_lane),
    .i_size    (w_size),
    .i_wdata   (req_wdata),
    .i_rdata   (CPUNC_RDATA),
    .o_wdata_c (w_wdata_c),
    .o_wstrb_c (w_wstrb_c),
    .o_rdata_c (w_rdata_c)
  );

  always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
    if (CPUNC_ARESET) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_err   = ERR_OK;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_hs) begin
          if (!w_legal) begin
            w_state_nxt = RSP;
            w_rsp_err   = ERR_ALIGN;
          end else begin
            w_state_nxt = req_write ? WR_AW_W : RD_A;
          end
        end
      end
      RD_A: begin
        if (w_ar_hs)        w_state_nxt = RD_D;
        else if (w_tmo_hit) w_abort = 1'b1;
      end
      RD_D: begin
        if (w_r_hs) begin
          w_state_nxt = RSP;
          w_rsp_err   = (CPUNC_RRESP != RESP_OKAY) ? ERR_BUS : ERR_OK;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      WR_AW_W: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = WR_B;
        else if (w_tmo_hit)                                 w_abort = 1'b1;
      end
      WR_B: begin
        if (w_b_hs) begin
          w_state_nxt = RSP;
          w_rsp_err   = (CPUNC_BRESP != RESP_OKAY) ? ERR_BUS : ERR_OK;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = RSP;
      w_rsp_err   = ERR_TIMEOUT;
    end
    // A timed-out transaction may still owe one R or B beat; swallow it while idle.
    w_drain_nxt = r_drain;
    if (((r_state == IDLE) || (r_state == RSP)) && (w_r_hs || w_b_hs)) w_drain_nxt = 1'b0;
    if (w_abort) w_drain_nxt = 1'b1;
  end

  always_ff @(posedge CPUNC_ACLK or posedge CPUNC_ARESET) begin
    if (CPUNC_ARESET) begin
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 64'd0;
      rsp_err       <= 2'b00;
      CPUNC_AWADDR  <= '0;
      CPUNC_AWSIZE  <= 3'd0;
      CPUNC_AWVALID <= 1'b0;
      CPUNC_WDATA   <= '0;
      CPUNC_WSTRB   <= '0;
      CPUNC_WLAST   <= 1'b0;
      CPUNC_WVALID  <= 1'b0;
      CPUNC_BREADY  <= 1'b0;
      CPUNC_ARADDR  <= '0;
      CPUNC_ARSIZE  <= 3'd0;
      CPUNC_ARVALID <= 1'b0;
      CPUNC_RREADY  <= 1'b0;
      r_drain       <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_tmo         <= 32'd0;
      r_lane        <= '0;
      r_size        <= 2'd0;
    end else begin
      req_ready    <= (w_state_nxt == IDLE);
      rsp_valid    <= (w_state_nxt == RSP);
      r_drain      <= w_drain_nxt;
      CPUNC_RREADY <= (w_state_nxt == RD_D) ||
                      (w_drain_nxt && ((w_state_nxt == IDLE) || (w_state_nxt == RSP)));
      CPUNC_BREADY <= (w_state_nxt == WR_B) ||
                      (w_drain_nxt && ((w_state_nxt == IDLE) || (w_state_nxt == RSP)));

      if (w_acc_rd || w_acc_wr) begin
        r_tmo  <= 32'd0;
        r_lane <= req_addr[LANE_W-1:0];
        r_size <= req_size;
      end else if ((r_state == RD_A) || (r_state == RD_D) ||
                   (r_state == WR_AW_W) || (r_state == WR_B)) begin
        r_tmo <= r_tmo + 32'd1;
      end

      if (w_acc_rd) begin
        CPUNC_ARADDR  <= req_addr;
        CPUNC_ARSIZE  <= {1'b0, req_size};
        CPUNC_ARVALID <= 1'b1;
      end else if (w_ar_hs || w_abort) begin
        CPUNC_ARVALID <= 1'b0;
      end

      // AW and W launch together and retire independently.
      if (w_acc_wr) begin
        CPUNC_AWADDR  <= req_addr;
        CPUNC_AWSIZE  <= {1'b0, req_size};
        CPUNC_AWVALID <= 1'b1;
        CPUNC_WDATA   <= w_wdata_c;
        CPUNC_WSTRB   <= w_wstrb_c;
        CPUNC_WVALID  <= 1'b1;
        CPUNC_WLAST   <= 1'b1;
        r_aw_done     <= 1'b0;
        r_w_done      <= 1'b0;
      end else begin
        if (w_aw_hs || w_abort) CPUNC_AWVALID <= 1'b0;
        if (w_aw_hs)            r_aw_done     <= 1'b1;
        if (w_w_hs || w_abort) begin
          CPUNC_WVALID <= 1'b0;
          CPUNC_WLAST  <= 1'b0;
        end
        if (w_w_hs) r_w_done <= 1'b1;
      end

      if ((r_state != RSP) && (w_state_nxt == RSP)) begin
        rsp_err   <= w_rsp_err;
        rsp_rdata <= ((r_state == RD_D) && w_r_hs) ? w_rdata_c : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_spike_axi_master.sv
// Directed bench for spike_axi_master: a 32-bit and a 64-bit instance, both with a 16-cycle timeout.
module tb_spike_axi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_req_addr;
  logic [1:0]  a_req_size, a_rsp_err;
  logic [63:0] a_req_wdata, a_rsp_rdata;
  logic [7:0]  a_awid, a_awlen, a_wid, a_bid, a_arid, a_arlen, a_rid;
  logic [31:0] a_awaddr, a_araddr, a_wdata, a_rdata;
  logic [2:0]  a_awsize, a_arsize;
  logic [1:0]  a_awburst, a_arburst, a_bresp, a_rresp;
  logic [3:0]  a_wstrb;
  logic        a_awvalid, a_awready, a_wlast, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rlast, a_rvalid, a_rready;

  // 64-bit instance
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
  logic [31:0] b_req_addr;
  logic [1:0]  b_req_size, b_rsp_err;
  logic [63:0] b_req_wdata, b_rsp_rdata;
  logic [7:0]  b_awid, b_awlen, b_wid, b_bid, b_arid, b_arlen, b_rid;
  logic [31:0] b_awaddr, b_araddr;
  logic [63:0] b_wdata, b_rdata;
  logic [2:0]  b_awsize, b_arsize;
  logic [1:0]  b_awburst, b_arburst, b_bresp, b_rresp;
  logic [7:0]  b_wstrb;
  logic        b_awvalid, b_awready, b_wlast, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rlast, b_rvalid, b_rready;

  spike_axi_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_ID(8'h5A), .TIMEOUT_CYCLES(16)) u_dut32 (
    .CPUNC_ACLK(clk), .CPUNC_ARESET(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_size(a_req_size), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .CPUNC_AWID(a_awid), .CPUNC_AWADDR(a_awaddr), .CPUNC_AWLEN(a_awlen), .CPUNC_AWSIZE(a_awsize),
    .CPUNC_AWBURST(a_awburst), .CPUNC_AWVALID(a_awvalid), .CPUNC_AWREADY(a_awready),
    .CPUNC_WID(a_wid), .CPUNC_WDATA(a_wdata), .CPUNC_WSTRB(a_wstrb), .CPUNC_WLAST(a_wlast),
    .CPUNC_WVALID(a_wvalid), .CPUNC_WREADY(a_wready),
    .CPUNC_BID(a_bid), .CPUNC_BRESP(a_bresp), .CPUNC_BVALID(a_bvalid), .CPUNC_BREADY(a_bready),
    .CPUNC_ARID(a_arid), .CPUNC_ARADDR(a_araddr), .CPUNC_ARLEN(a_arlen), .CPUNC_ARSIZE(a_arsize),
    .CPUNC_ARBURST(a_arburst), .CPUNC_ARVALID(a_arvalid), .CPUNC_ARREADY(a_arready),
    .CPUNC_RID(a_rid), .CPUNC_RDATA(a_rdata), .CPUNC_RRESP(a_rresp), .CPUNC_RLAST(a_rlast),
    .CPUNC_RVALID(a_rvalid), .CPUNC_RREADY(a_rready)
  );

  spike_axi_master #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID(8'h00), .TIMEOUT_CYCLES(16)) u_dut64 (
    .CPUNC_ACLK(clk), .CPUNC_ARESET(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_size(b_req_size), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .CPUNC_AWID(b_awid), .CPUNC_AWADDR(b_awaddr), .CPUNC_AWLEN(b_awlen), .CPUNC_AWSIZE(b_awsize),
    .CPUNC_AWBURST(b_awburst), .CPUNC_AWVALID(b_awvalid), .CPUNC_AWREADY(b_awready),
    .CPUNC_WID(b_wid), .CPUNC_WDATA(b_wdata), .CPUNC_WSTRB(b_wstrb), .CPUNC_WLAST(b_wlast),
    .CPUNC_WVALID(b_wvalid), .CPUNC_WREADY(b_wready),
    .CPUNC_BID(b_bid), .CPUNC_BRESP(b_bresp), .CPUNC_BVALID(b_bvalid), .CPUNC_BREADY(b_bready),
    .CPUNC_ARID(b_arid), .CPUNC_ARADDR(b_araddr), .CPUNC_ARLEN(b_arlen), .CPUNC_ARSIZE(b_arsize),
    .CPUNC_ARBURST(b_arburst), .CPUNC_ARVALID(b_arvalid), .CPUNC_ARREADY(b_arready),
    .CPUNC_RID(b_rid), .CPUNC_RDATA(b_rdata), .CPUNC_RRESP(b_rresp), .CPUNC_RLAST(b_rlast),
    .CPUNC_RVALID(b_rvalid), .CPUNC_RREADY(b_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request to the 64-bit instance for a single accepting edge.
  task automatic b_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata);
    b_req_write = wr; b_req_addr = addr; b_req_size = size; b_req_wdata = wdata;
    b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
  endtask

  task automatic b_rsp_take();
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ar;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_size = 0; a_req_wdata = 0; a_rsp_ready = 0;
    a_awready = 0; a_wready = 0; a_bid = 0; a_bresp = 0; a_bvalid = 0; a_arready = 0;
    a_rid = 0; a_rdata = 0; a_rresp = 0; a_rlast = 1; a_rvalid = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_size = 0; b_req_wdata = 0; b_rsp_ready = 0;
    b_awready = 0; b_wready = 0; b_bid = 0; b_bresp = 0; b_bvalid = 0; b_arready = 0;
    b_rid = 0; b_rdata = 0; b_rresp = 0; b_rlast = 1; b_rvalid = 0;

    // Reset values
    tick(); tick();
    chk("rst_req_ready", 64'(b_req_ready), 64'd0);
    chk("rst_arvalid",   64'(b_arvalid),   64'd0);
    chk("rst_awvalid",   64'(b_awvalid),   64'd0);
    chk("rst_wvalid",    64'(b_wvalid),    64'd0);
    chk("rst_rready",    64'(b_rready),    64'd0);
    chk("rst_bready",    64'(b_bready),    64'd0);
    chk("rst_rsp_valid", 64'(b_rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(b_rsp_err),   64'd0);
    chk("rst_rsp_rdata", b_rsp_rdata,      64'd0);
    chk("rst_wstrb",     64'(b_wstrb),     64'd0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready32", 64'(a_req_ready), 64'd1);
    chk("idle_req_ready64", 64'(b_req_ready), 64'd1);

    // DW=32 halfword write to 0x102, slave always ready
    a_awready = 1; a_wready = 1;
    a_req_write = 1; a_req_addr = 32'h102; a_req_size = 2'd1; a_req_wdata = 64'hBEEF;
    a_req_valid = 1;
    tick();
    a_req_valid = 0;
    chk("w32_awvalid", 64'(a_awvalid), 64'd1);
    chk("w32_wvalid",  64'(a_wvalid),  64'd1);
    chk("w32_wlast",   64'(a_wlast),   64'd1);
    chk("w32_wdata",   64'(a_wdata),   64'hBEEF_0000);
    chk("w32_wstrb",   64'(a_wstrb),   64'hC);
    chk("w32_awsize",  64'(a_awsize),  64'd1);
    chk("w32_awaddr",  64'(a_awaddr),  64'h102);
    chk("w32_awburst", 64'(a_awburst), 64'd1);
    chk("w32_awid",    64'(a_awid),    64'h5A);
    chk("w32_req_ready_busy", 64'(a_req_ready), 64'd0);
    tick();
    chk("w32_aw_drop", 64'(a_awvalid), 64'd0);
    chk("w32_w_drop",  64'(a_wvalid),  64'd0);
    chk("w32_bready",  64'(a_bready),  64'd1);
    a_bvalid = 1;
    tick();
    a_bvalid = 0;
    chk("w32_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("w32_rsp_err",   64'(a_rsp_err),   64'd0);
    chk("w32_bready_off", 64'(a_bready),   64'd0);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    chk("w32_rsp_done",  64'(a_rsp_valid), 64'd0);
    chk("w32_req_ready", 64'(a_req_ready), 64'd1);

    // DW=32 doubleword request is illegal
    a_req_write = 0; a_req_addr = 32'h8; a_req_size = 2'd3; a_req_valid = 1;
    tick();
    a_req_valid = 0;
    chk("sz3_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("sz3_rsp_err",   64'(a_rsp_err),   64'd2);
    chk("sz3_arvalid",   64'(a_arvalid),   64'd0);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;

    // DW=64 word read from 0x1004 (upper lanes)
    b_arready = 1;
    b_req(1'b0, 32'h1004, 2'd2, 64'd0);
    chk("r64_arvalid", 64'(b_arvalid), 64'd1);
    chk("r64_araddr",  64'(b_araddr),  64'h1004);
    chk("r64_arsize",  64'(b_arsize),  64'd2);
    chk("r64_arlen",   64'(b_arlen),   64'd0);
    tick();
    chk("r64_ar_drop", 64'(b_arvalid), 64'd0);
    chk("r64_rready",  64'(b_rready),  64'd1);
    b_rvalid = 1; b_rdata = 64'h1122_3344_5566_7788; b_rresp = 2'b00;
    tick();
    b_rvalid = 0;
    chk("r64_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("r64_rsp_rdata", b_rsp_rdata,      64'h0000_0000_1122_3344);
    chk("r64_rsp_err",   64'(b_rsp_err),   64'd0);
    chk("r64_rready_off", 64'(b_rready),   64'd0);
    tick();
    chk("r64_rsp_hold",  64'(b_rsp_valid), 64'd1);
    chk("r64_rdata_hold", b_rsp_rdata,     64'h0000_0000_1122_3344);
    b_rsp_take();
    b_arready = 0;

    // DW=64 doubleword write, AWREADY held off for three cycles
    b_awready = 0; b_wready = 1;
    b_req(1'b1, 32'h10, 2'd3, 64'h0123_4567_89AB_CDEF);
    chk("dly_awvalid_c1", 64'(b_awvalid), 64'd1);
    chk("dly_wvalid_c1",  64'(b_wvalid),  64'd1);
    chk("dly_wstrb",      64'(b_wstrb),   64'hFF);
    chk("dly_wdata",      b_wdata,        64'h0123_4567_89AB_CDEF);
    tick();
    chk("dly_wvalid_c2",  64'(b_wvalid),  64'd0);
    chk("dly_awvalid_c2", 64'(b_awvalid), 64'd1);
    tick();
    tick();
    chk("dly_awvalid_c4", 64'(b_awvalid), 64'd1);
    chk("dly_bready_c4",  64'(b_bready),  64'd0);
    b_awready = 1;
    tick();
    b_awready = 0;
    chk("dly_awvalid_c5", 64'(b_awvalid), 64'd0);
    chk("dly_bready_c5",  64'(b_bready),  64'd1);
    b_bvalid = 1; b_bresp = 2'b00;
    tick();
    b_bvalid = 0;
    chk("dly_rsp_valid",  64'(b_rsp_valid), 64'd1);
    chk("dly_bready_off", 64'(b_bready),    64'd0);
    chk("dly_rsp_err",    64'(b_rsp_err),   64'd0);
    chk("dly_rsp_rdata",  b_rsp_rdata,      64'd0);
    b_rsp_take();
    chk("dly_req_ready",  64'(b_req_ready), 64'd1);

    // Misaligned word read never reaches the bus
    b_req(1'b0, 32'h3, 2'd2, 64'd0);
    chk("mis_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("mis_rsp_err",   64'(b_rsp_err),   64'd2);
    chk("mis_arvalid",   64'(b_arvalid),   64'd0);
    b_rsp_take();
    chk("mis_arvalid_after", 64'(b_arvalid), 64'd0);

    // Word write to upper lanes answered with SLVERR
    b_awready = 1; b_wready = 1;
    b_req(1'b1, 32'hC, 2'd2, 64'hCAFE_BABE);
    chk("slv_wdata", b_wdata,       64'hCAFE_BABE_0000_0000);
    chk("slv_wstrb", 64'(b_wstrb),  64'hF0);
    chk("slv_awsize", 64'(b_awsize), 64'd2);
    tick();
    chk("slv_bready", 64'(b_bready), 64'd1);
    b_bvalid = 1; b_bresp = 2'b10;
    tick();
    b_bvalid = 0; b_bresp = 2'b00;
    chk("slv_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("slv_rsp_err",   64'(b_rsp_err),   64'd1);
    b_rsp_take();
    b_awready = 0; b_wready = 0;

    // Read with ARREADY never asserted: timeout, then a late R beat is drained
    b_req(1'b0, 32'h20, 2'd3, 64'd0);
    n_ar = 0;
    for (int i = 0; i < 40; i++) begin
      if (!b_arvalid) break;
      n_ar++;
      tick();
    end
    chk("tmo_arvalid_cycles", 64'(n_ar), 64'd16);
    chk("tmo_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("tmo_rsp_err",   64'(b_rsp_err),   64'd3);
    chk("tmo_rsp_rdata", b_rsp_rdata,      64'd0);
    chk("tmo_drain_rsp", 64'(b_rready),    64'd1);
    b_rsp_take();
    chk("tmo_req_ready",  64'(b_req_ready), 64'd1);
    chk("tmo_drain_idle", 64'(b_rready),    64'd1);
    b_rvalid = 1; b_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    b_rvalid = 0;
    chk("tmo_drain_done", 64'(b_rready),    64'd0);
    chk("tmo_no_rsp",     64'(b_rsp_valid), 64'd0);
    b_arready = 1;
    b_req(1'b0, 32'h1004, 2'd2, 64'd0);
    chk("post_arvalid", 64'(b_arvalid), 64'd1);
    tick();
    b_rvalid = 1; b_rdata = 64'hA5A5_A5A5_5A5A_5A5A; b_rresp = 2'b00;
    tick();
    b_rvalid = 0;
    chk("post_rsp_valid", 64'(b_rsp_valid), 64'd1);
    chk("post_rsp_rdata", b_rsp_rdata,      64'h0000_0000_A5A5_A5A5);
    chk("post_rsp_err",   64'(b_rsp_err),   64'd0);
    b_rsp_take();

    // Reset asserted while waiting in RD_D
    b_req(1'b0, 32'h40, 2'd0, 64'd0);
    tick();
    chk("mid_rready", 64'(b_rready), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rready",    64'(b_rready),    64'd0);
    chk("mid_rst_arvalid",   64'(b_arvalid),   64'd0);
    chk("mid_rst_req_ready", 64'(b_req_ready), 64'd0);
    chk("mid_rst_araddr",    64'(b_araddr),    64'd0);
    chk("mid_rst_arsize",    64'(b_arsize),    64'd0);
    chk("mid_rst_rsp_valid", 64'(b_rsp_valid), 64'd0);
    b_arready = 0;
    rst = 1'b0;
    tick();
    chk("mid_rel_req_ready", 64'(b_req_ready), 64'd1);
    chk("mid_rel_rsp_valid", 64'(b_rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
